// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions used by the execute-stage blocks: datapath widths,
// multiply/divide operation encodings and the multiply/divide FSM state type.
package muldiv_unit_pkg;

   localparam int CPU_WIDTH          = 24;
   localparam int CPU_REG_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      OP_MUL  = 2'b00,
      OP_MULH = 2'b01,
      OP_DIV  = 2'b10,
      OP_REM  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring
// divide sharing one hi/lo register pair, one bit per cycle, fixed WIDTH-cycle latency.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH          = CPU_WIDTH,
   parameter int REG_ADDR_WIDTH = CPU_REG_ADDR_WIDTH
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Start,
   input  logic [1:0]                Op,
   input  logic [WIDTH-1:0]          OperandA,
   input  logic [WIDTH-1:0]          OperandB,
   input  logic [REG_ADDR_WIDTH-1:0] DestIn,
   output logic                      Busy,
   output logic                      Done,
   output logic [WIDTH-1:0]          Result,
   output logic [REG_ADDR_WIDTH-1:0] DestOut
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   // Handshake: Start is taken only while Busy is low; Busy stays high through
   // RUN and DONE, and Done is a single-cycle strobe carrying Result/DestOut.
   mdu_state_e                state_q;
   mdu_op_e                   op_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [WIDTH-1:0]          hi_q, hi_d;
   logic [WIDTH-1:0]          lo_q, lo_d;
   logic [WIDTH-1:0]          b_q;
   logic [WIDTH-1:0]          result_q, result_d;
   logic [REG_ADDR_WIDTH-1:0] dest_q;
   logic                      busy_q;
   logic                      done_q;

   logic [WIDTH:0]            sum;
   logic [WIDTH:0]            rem_trial;
   logic [WIDTH-1:0]          mul_addend;

   // Multiply: hi:lo is the product, lo initially the multiplier shifted out LSB first.
   // Divide: hi is the partial remainder, lo the dividend shifting out MSB first
   // while quotient bits shift in behind it.
   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      sum        = '0;
      rem_trial  = '0;
      mul_addend = lo_q[0] ? b_q : '0;
      if (op_q == OP_MUL || op_q == OP_MULH) begin
         sum  = {1'b0, hi_q} + {1'b0, mul_addend};
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], lo_q[WIDTH-1:1]};
      end else begin
         rem_trial = {hi_q, lo_q[WIDTH-1]};
         if (rem_trial >= {1'b0, b_q}) begin
            hi_d = WIDTH'(rem_trial - {1'b0, b_q});
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = WIDTH'(rem_trial);
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
      result_d = (op_q == OP_MULH || op_q == OP_REM) ? hi_d : lo_d;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         result_q <= '0;
         dest_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  state_q <= ST_RUN;
                  op_q    <= mdu_op_e'(Op);
                  hi_q    <= '0;
                  lo_q    <= OperandA;
                  b_q     <= OperandB;
                  dest_q  <= DestIn;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state_q  <= ST_DONE;
                  result_q <= result_d;
                  done_q   <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Result  = result_q;
   assign DestOut = dest_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written corner sequences.
module tb_muldiv_unit;

   localparam int W  = 24;
   localparam int AW = 4;

   logic          Clock;
   logic          Reset;
   logic          Start;
   logic [1:0]    Op;
   logic [W-1:0]  OperandA;
   logic [W-1:0]  OperandB;
   logic [AW-1:0] DestIn;
   logic          Busy;
   logic          Done;
   logic [W-1:0]  Result;
   logic [AW-1:0] DestOut;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [AW-1:0] dest;
      logic [W-1:0]  exp_res;
   } vec_t;

   vec_t vecs[9];

   muldiv_unit dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Op       (Op),
      .OperandA (OperandA),
      .OperandB (OperandB),
      .DestIn   (DestIn),
      .Busy     (Busy),
      .Done     (Done),
      .Result   (Result),
      .DestOut  (DestOut)
   );

   // ---------------- clock / reset ----------------
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = (2*W)'(a) * (2*W)'(b);
      case (op)
         2'b00:   return p[W-1:0];
         2'b01:   return p[2*W-1:W];
         2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, output logic [W-1:0] res,
                         output logic [AW-1:0] dout, output int lat);
      @(negedge Clock);
      Start = 1'b1; Op = op; OperandA = a; OperandB = b; DestIn = d;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      Op = 2'($urandom); OperandA = W'($urandom); OperandB = W'($urandom); DestIn = AW'($urandom);
      check("busy_after_start", 32'(Busy), 32'd1);
      lat = -1; res = '0; dout = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge Clock);
         #1;
         if (Done) begin
            lat  = i;
            res  = Result;
            dout = DestOut;
            break;
         end
      end
      if (lat > 0) begin
         @(posedge Clock);
         #1;
         check("done_one_cycle", 32'(Done), 32'd0);
         check("busy_clears", 32'(Busy), 32'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0]  res;
      logic [AW-1:0] dout;
      logic [W-1:0]  ra, rb, exp_res;
      logic [1:0]    rop;
      logic [AW-1:0] rd;
      int            lat, ndone, first_done;
      logic [W-1:0]  first_res;
      logic [AW-1:0] first_dest;

      vecs[0] = '{2'b00, 24'h000123, 24'h000456, 4'd3,  24'h04EDC2};
      vecs[1] = '{2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd1,  24'h000001};
      vecs[2] = '{2'b01, 24'hFFFFFF, 24'hFFFFFF, 4'd2,  24'hFFFFFE};
      vecs[3] = '{2'b10, 24'd100,    24'd7,      4'd4,  24'h00000E};
      vecs[4] = '{2'b11, 24'd100,    24'd7,      4'd5,  24'h000002};
      vecs[5] = '{2'b10, 24'h00ABCD, 24'h000000, 4'd6,  24'hFFFFFF};
      vecs[6] = '{2'b11, 24'h00ABCD, 24'h000000, 4'd15, 24'h00ABCD};
      vecs[7] = '{2'b01, 24'h000123, 24'h000456, 4'd8,  24'h000000};
      vecs[8] = '{2'b10, 24'h000005, 24'hFFFFFF, 4'd9,  24'h000000};

      Reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0; DestIn = '0;
      repeat (3) @(posedge Clock);
      #1;
      check("reset_busy", 32'(Busy), 32'd0);
      check("reset_done", 32'(Done), 32'd0);
      check("reset_result", 32'(Result), 32'd0);
      check("reset_dest", 32'(DestOut), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      // directed table
      for (int v = 0; v < 9; v++) begin
         run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].dest, res, dout, lat);
         check($sformatf("vec%0d_latency", v), 32'(lat), 32'd24);
         check($sformatf("vec%0d_result", v), 32'(res), 32'(vecs[v].exp_res));
         check($sformatf("vec%0d_dest", v), 32'(dout), 32'(vecs[v].dest));
      end

      // randomized against the model
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 255));
            default: rb = W'($urandom);
         endcase
         rd = AW'($urandom);
         exp_q.push_back(model(rop, ra, rb));
         run_op(rop, ra, rb, rd, res, dout, lat);
         exp_res = exp_q.pop_front();
         check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd24);
         check($sformatf("rnd%0d_op%0d_result", n, rop), 32'(res), 32'(exp_res));
         check($sformatf("rnd%0d_dest", n), 32'(dout), 32'(rd));
      end

      // Start during RUN must be ignored
      @(negedge Clock);
      Start = 1'b1; Op = 2'b10; OperandA = 24'd1000; OperandB = 24'd3; DestIn = 4'd5;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      ndone = 0; first_done = -1; first_res = '0; first_dest = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            Start = 1'b1; Op = 2'b00; OperandA = 24'd9; OperandB = 24'd9; DestIn = 4'd9;
         end
         if (i == 6) Start = 1'b0;
         @(posedge Clock);
         #1;
         if (Done) begin
            ndone++;
            if (first_done < 0) begin
               first_done = i; first_res = Result; first_dest = DestOut;
            end
         end
      end
      check("ignored_start_latency", 32'(first_done), 32'd24);
      check("ignored_start_result", 32'(first_res), 32'd333);
      check("ignored_start_dest", 32'(first_dest), 32'd5);
      check("ignored_start_done_count", 32'(ndone), 32'd1);

      // asynchronous reset mid-multiply
      @(negedge Clock);
      Start = 1'b1; Op = 2'b00; OperandA = 24'h001234; OperandB = 24'h000010; DestIn = 4'd7;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      repeat (10) @(posedge Clock);
      #3;
      Reset = 1'b1;
      #1;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_result", 32'(Result), 32'd0);
      check("abort_dest", 32'(DestOut), 32'd0);
      @(posedge Clock);
      #2;
      Reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clock);
         #1;
         if (Done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      check("abort_result_stays", 32'(Result), 32'd0);
      run_op(2'b00, 24'h001234, 24'h000010, 4'd7, res, dout, lat);
      check("post_reset_latency", 32'(lat), 32'd24);
      check("post_reset_result", 32'(res), 32'h012340);
      check("post_reset_dest", 32'(dout), 32'd7);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit for the 24-bit CPU. It sits beside the ALU in the execute stage. It consumes the register file's two read ports as operands and produces a result, destination index and one-cycle write strobe that drive the register file's write port (WriteData, RD, RegWrite) through the writeback mux. One operation runs at a time with fixed latency; the control unit stalls on Busy.

## Interface
Parameters:
- WIDTH, 24, operand/result width
- REG_ADDR_WIDTH, 4, register index width (16 architectural registers)

Ports:
- Clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Start  in  1  request; sampled only in IDLE
- Op  in  2  operation: 00 MUL (low WIDTH bits of product), 01 MULH (high WIDTH bits), 10 DIV (quotient), 11 REM (remainder)
- OperandA  in  WIDTH  multiplicand / dividend (from ReadRS)
- OperandB  in  WIDTH  multiplier / divisor (from ReadRT)
- DestIn  in  REG_ADDR_WIDTH  destination register index
- Busy  out  1  high in RUN and DONE
- Done  out  1  one-cycle strobe; drives RegWrite of the write port
- Result  out  WIDTH  result; drives WriteData
- DestOut  out  REG_ADDR_WIDTH  captured DestIn; drives RD

## Operation
- All arithmetic is unsigned.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN: Start=1. Capture OperandA, OperandB, Op and DestIn; clear the step counter.
  - RUN → DONE: the counter reaches WIDTH-1 and its step is applied. Register the result selected by Op into Result.
  - DONE → IDLE: unconditional.
- Start while in RUN or DONE is ignored. It is not queued.
- Multiply is shift-add over a 2·WIDTH product register: one multiplier bit per RUN cycle, LSB first. MUL returns product[WIDTH-1:0]; MULH returns product[2·WIDTH-1:WIDTH].
- Divide is restoring division with a WIDTH+1-bit partial remainder: one dividend bit per cycle, MSB first.
  - Each step: R = {R,bit}; if R ≥ divisor then R −= divisor and the quotient bit is 1, else the quotient bit is 0.
- Divide by zero needs no special path and has the same latency. It yields quotient = all ones (0xFFFFFF) and remainder = dividend.
- Result and DestOut hold their value until the next accepted Start. Done is high only while in DONE.
- Reset values: Busy=0, Done=0, Result=0, DestOut=0; state=IDLE; counter and internal registers are 0.
- Reset mid-operation aborts it. No Done is produced and no partial result appears on Result.

## Timing
- Start is accepted at edge k. Busy=1 from after edge k.
- RUN covers edges k+1 … k+WIDTH (24 iteration steps).
- After edge k+WIDTH: DONE, with Done=1 and Result/DestOut valid.
- After edge k+WIDTH+1: IDLE, with Busy=0 and Done=0.
- Latency from Start to Done is WIDTH cycles. The earliest next Start is accepted at edge k+WIDTH+2.
- Operand inputs may change freely after edge k.
- No combinational path exists from inputs to outputs. All outputs are registered.

## Structure
- Shared CPU package holds:
  - the Op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM);
  - the WIDTH and REG_ADDR_WIDTH defaults, shared with the register file and ALU.
- The block is a single module: FSM, counter of width clog2(WIDTH), and one shared datapath. No sub-module; the multiply and divide step logic is small enough to stay inline.

## Test plan
- MUL 0x000123 × 0x000456, DestIn=3 → Done exactly 24 cycles after Start; Result=0x04EDC2, DestOut=3, Done high for one cycle.
- MUL and MULH of 0xFFFFFF × 0xFFFFFF → MUL Result=0x000001; MULH Result=0xFFFFFE.
- DIV 100 ÷ 7 → Result=0x00000E; REM 100 ÷ 7 → Result=0x000002.
- DIV and REM of 0x00ABCD ÷ 0 → DIV Result=0xFFFFFF; REM Result=0x00ABCD; latency unchanged at 24 cycles.
- Start pulsed again at cycle 5 of a DIV with different operands → ignored. The original result and DestOut appear at cycle 24, and only one Done pulse occurs.
- Reset asserted asynchronously at cycle 10 of a MUL → Busy, Done, Result and DestOut drop to 0 immediately; no Done follows; a fresh MUL after release completes correctly.
